execute_mc: RTL and testbench

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_execute_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, ALU with flags, branch resolution and an
// optional iterative shift-add multiplier that stalls the front end while busy.
module execute_mc #(
   parameter int WIDTH  = 16,
   parameter int RADDR  = 3,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             flush,
   input  logic [2:0]       opcode,
   input  logic [3:0]       alu_op,
   input  logic [3:0]       cond,
   input  logic [RADDR-1:0] s1,
   input  logic [RADDR-1:0] s2,
   input  logic [RADDR-1:0] tgt,
   input  logic [WIDTH-1:0] reg_out_1,
   input  logic [WIDTH-1:0] reg_out_2,
   input  logic [WIDTH-1:0] imm,
   input  logic             imm_sel,
   input  logic [WIDTH-1:0] pc,
   input  logic             wb_valid,
   input  logic [RADDR-1:0] wb_tgt,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] store_data,
   output logic [RADDR-1:0] tgt_out,
   output logic             out_valid,
   output logic             stall,
   output logic             branch,
   output logic [WIDTH-1:0] branch_tgt
);

   localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SHL  = 4'd5,
      ALU_SHR  = 4'd6,
      ALU_PASS = 4'd7,
      ALU_MUL  = 4'd8
   } alu_e;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q;
   logic [CW-1:0]    count_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q, store_q;
   logic [RADDR-1:0] tgt_q, mtgt_q;
   logic             valid_q;
   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;

   logic [WIDTH-1:0] op1, op2, lhs, rhs;
   logic [WIDTH:0]   add_full, sub_full;
   logic [WIDTH-1:0] alu_res;
   logic             flag_z, flag_n, flag_c, flag_v;
   logic             cond_true;
   logic             br_take;
   logic [WIDTH-1:0] pc_next, br_target;
   logic             mul_accept;
   logic [WIDTH-1:0] acc_d, mul_final;

   // Index 0 is hard-wired, so it never forwards.
   assign op1 = (s1 == '0)                   ? reg_out_1 :
                (valid_q && tgt_q == s1)     ? result_q  :
                (wb_valid && wb_tgt == s1)   ? wb_result : reg_out_1;
   assign op2 = (s2 == '0)                   ? reg_out_2 :
                (valid_q && tgt_q == s2)     ? result_q  :
                (wb_valid && wb_tgt == s2)   ? wb_result : reg_out_2;

   assign lhs = op1;
   assign rhs = imm_sel ? imm : op2;

   assign add_full = {1'b0, lhs} + {1'b0, rhs};
   assign sub_full = {1'b0, lhs} + {1'b0, ~rhs} + {{WIDTH{1'b0}}, 1'b1};

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res = add_full[WIDTH-1:0];
      flag_c  = 1'b0;
      flag_v  = 1'b0;
      case (alu_op)
         ALU_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            flag_c  = sub_full[WIDTH];
            flag_v  = (lhs[MSB] != rhs[MSB]) && (sub_full[MSB] != lhs[MSB]);
         end
         ALU_AND:  alu_res = lhs & rhs;
         ALU_OR:   alu_res = lhs | rhs;
         ALU_XOR:  alu_res = lhs ^ rhs;
         ALU_SHL:  alu_res = lhs << rhs[SHW-1:0];
         ALU_SHR:  alu_res = lhs >> rhs[SHW-1:0];
         ALU_PASS: alu_res = rhs;
         default: begin
            flag_c = add_full[WIDTH];
            flag_v = (lhs[MSB] == rhs[MSB]) && (add_full[MSB] != lhs[MSB]);
         end
      endcase
   end

   assign flag_z = (alu_res == '0);
   assign flag_n = alu_res[MSB];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'd0: cond_true = flag_z;
         4'd1: cond_true = !flag_z && !flag_n;
         4'd2: cond_true = flag_n;
         4'd3: cond_true = flag_c;
         4'd4: cond_true = flag_v;
         4'd5: cond_true = !flag_z;
         4'd6: cond_true = 1'b1;
         4'd7: cond_true = !flag_c;
         default: cond_true = 1'b0;
      endcase
   end

   assign pc_next = pc + ONE_W;

   always_comb begin
      br_take   = 1'b0;
      br_target = pc_next;
      case (opcode)
         3'b110: begin
            br_take   = cond_true;
            br_target = cond_true ? pc_next + imm : pc_next;
         end
         3'b111: begin
            br_take   = 1'b1;
            br_target = alu_res;
         end
         default: ;
      endcase
   end

   // done_q marks the cycle in which a finished multiply is still held on the
   // inputs (stall was high at its last edge); it retires without re-issuing.
   assign mul_accept = MUL_EN && (state_q == IDLE) && !done_q && in_valid && !flush &&
                       (alu_op == ALU_MUL);
   assign stall      = mul_accept || (state_q == BUSY);
   assign branch     = br_take && in_valid && !flush && !stall && !done_q;
   assign branch_tgt = br_target;

   assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
   // The accept cycle performs no step, so the last edge also folds in the top multiplier bit.
   assign mul_final = acc_d + (mplier_q[1] ? (mcand_q << 1) : '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         store_q  <= '0;
         tgt_q    <= '0;
         valid_q  <= 1'b0;
         mtgt_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mul_accept) begin
                  state_q  <= BUSY;
                  mcand_q  <= lhs;
                  mplier_q <= rhs;
                  acc_q    <= '0;
                  mtgt_q   <= tgt;
                  count_q  <= CNT_LOAD;
               end else if (!done_q) begin
                  result_q <= alu_res;
                  store_q  <= op2;
                  tgt_q    <= tgt;
                  valid_q  <= in_valid && !flush;
               end
            end
            BUSY: begin
               if (flush) begin
                  state_q <= IDLE;
                  count_q <= '0;
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  count_q  <= count_q - CNT_ONE;
                  // The finishing edge is the one that brings the count to zero.
                  if (count_q == CNT_ONE) begin
                     result_q <= mul_final;
                     tgt_q    <= mtgt_q;
                     valid_q  <= 1'b1;
                     done_q   <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result     = result_q;
   assign store_data = store_q;
   assign tgt_out    = tgt_q;
   assign out_valid  = valid_q;

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: a scoreboard queue holds expected
// write-backs, popped whenever out_valid is seen.
module tb_execute_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, imm_sel, wb_valid;
   logic [2:0]  opcode, s1, s2, tgt, wb_tgt, tgt_out;
   logic [3:0]  alu_op, cond;
   logic [15:0] reg_out_1, reg_out_2, imm, pc, wb_result;
   logic [15:0] result, store_data, branch_tgt;
   logic        out_valid, stall, branch;

   always #5 clk = ~clk;

   execute_mc #(.WIDTH(16), .RADDR(3), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .opcode(opcode), .alu_op(alu_op), .cond(cond),
      .s1(s1), .s2(s2), .tgt(tgt),
      .reg_out_1(reg_out_1), .reg_out_2(reg_out_2),
      .imm(imm), .imm_sel(imm_sel), .pc(pc),
      .wb_valid(wb_valid), .wb_tgt(wb_tgt), .wb_result(wb_result),
      .result(result), .store_data(store_data), .tgt_out(tgt_out),
      .out_valid(out_valid), .stall(stall),
      .branch(branch), .branch_tgt(branch_tgt)
   );

   typedef struct packed {
      logic [15:0] res;
      logic [2:0]  tgt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Flag table: r1, r2, cond, expected branch, expected ADD result.
   logic [15:0] ft_r1  [10] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF,
                                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
   logic [15:0] ft_r2  [10] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                                16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
   logic [3:0]  ft_cond[10] = '{4'd4, 4'd2, 4'd3, 4'd1, 4'd3, 4'd0, 4'd7, 4'd4, 4'd8, 4'd6};
   logic        ft_br  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [15:0] ft_res [10] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] res, input logic [2:0] t);
      exp_t e;
      e.res = res;
      e.tgt = t;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; opcode = '0; alu_op = '0; cond = '0;
      s1 = '0; s2 = '0; tgt = '0; reg_out_1 = '0; reg_out_2 = '0;
      imm = '0; imm_sel = 1'b0; pc = '0;
   endtask

   task automatic drive(input logic [2:0] op, input logic [3:0] aop, input logic [3:0] cnd,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] t,
                        input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] im,
                        input logic isel, input logic [15:0] p);
      in_valid = 1'b1; flush = 1'b0; opcode = op; alu_op = aop; cond = cnd;
      s1 = a; s2 = b; tgt = t; reg_out_1 = r1; reg_out_2 = r2;
      imm = im; imm_sel = isel; pc = p;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_result", 32'(result), 32'(e.res));
            check("sb_tgt", 32'(tgt_out), 32'(e.tgt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int nv;
      rst = 1'b1;
      wb_valid = 1'b0; wb_tgt = '0; wb_result = '0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_result", 32'(result), 32'd0);
      check("rst_store", 32'(store_data), 32'd0);
      check("rst_tgt", 32'(tgt_out), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      tick();

      // Forwarding: result path beats writeback path; index 0 never forwards.
      wb_valid = 1'b1; wb_tgt = 3'd1; wb_result = 16'd99;
      drive(3'b000, 4'd0, 4'd0, 3'd2, 3'd3, 3'd1, 16'd5, 16'd3, 16'd0, 1'b0, 16'h0000);
      push(16'd8, 3'd1);
      @(negedge clk);
      check("alu_no_branch", 32'(branch), 32'd0);
      check("alu_branch_tgt", 32'(branch_tgt), 32'h0001);
      tick();
      drive(3'b000, 4'd0, 4'd0, 3'd1, 3'd0, 3'd2, 16'd0, 16'd0, 16'd1, 1'b1, 16'h0000);
      push(16'd9, 3'd2);
      tick();
      wb_tgt = 3'd3; wb_result = 16'd40;
      drive(3'b000, 4'd0, 4'd0, 3'd3, 3'd0, 3'd0, 16'd0, 16'd0, 16'd2, 1'b1, 16'h0000);
      push(16'd42, 3'd0);
      tick();
      wb_tgt = 3'd0; wb_result = 16'd55;
      drive(3'b000, 4'd0, 4'd0, 3'd0, 3'd0, 3'd4, 16'd7, 16'd0, 16'd1, 1'b1, 16'h0000);
      push(16'd8, 3'd4);
      tick();
      wb_valid = 1'b0;

      // Shifts use only the low 4 bits of rhs.
      drive(3'b000, 4'd5, 4'd0, 3'd5, 3'd0, 3'd5, 16'h0003, 16'd0, 16'd4, 1'b1, 16'h0000);
      push(16'h0030, 3'd5);
      tick();
      drive(3'b000, 4'd6, 4'd0, 3'd6, 3'd0, 3'd6, 16'h8000, 16'd0, 16'h0013, 1'b1, 16'h0000);
      push(16'h1000, 3'd6);
      tick();
      idle();
      tick();

      // Multiply 300*7: WIDTH stall cycles, then a one-cycle result pulse.
      drive(3'b000, 4'd8, 4'd0, 3'd1, 3'd2, 3'd3, 16'd300, 16'd7, 16'd0, 1'b0, 16'h0000);
      push(16'd2100, 3'd3);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stall !== 1'b1) break;
         cnt++;
         check("mul_busy_no_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("mul_stall_cycles", 32'(cnt), 32'd16);
      check("mul_valid", 32'(out_valid), 32'd1);
      check("mul_result", 32'(result), 32'd2100);
      tick();
      idle();
      @(negedge clk);
      check("mul_pulse_width", 32'(out_valid), 32'd0);
      check("mul_stall_after", 32'(stall), 32'd0);
      tick();

      // Flush on BUSY cycle 5 aborts the multiply.
      drive(3'b000, 4'd8, 4'd0, 3'd1, 3'd2, 3'd3, 16'd300, 16'd7, 16'd0, 1'b0, 16'h0000);
      @(negedge clk);
      check("flush_accept_stall", 32'(stall), 32'd1);
      tick();
      repeat (4) tick();
      flush = 1'b1;
      @(negedge clk);
      check("flush_busy_stall", 32'(stall), 32'd1);
      tick();
      drive(3'b000, 4'd0, 4'd0, 3'd0, 3'd0, 3'd5, 16'd10, 16'd20, 16'd0, 1'b0, 16'h0000);
      push(16'd30, 3'd5);
      @(negedge clk);
      check("flush_stall_low", 32'(stall), 32'd0);
      check("flush_no_valid", 32'(out_valid), 32'd0);
      tick();
      idle();
      @(negedge clk);
      check("flush_add_valid", 32'(out_valid), 32'd1);
      tick();

      // Compare-and-branch on !Z.
      drive(3'b110, 4'd1, 4'd5, 3'd6, 3'd7, 3'd0, 16'd4, 16'd4, 16'hFFFC, 1'b0, 16'h0010);
      push(16'd0, 3'd0);
      @(negedge clk);
      check("br_eq_branch", 32'(branch), 32'd0);
      check("br_eq_tgt", 32'(branch_tgt), 32'h0011);
      tick();
      drive(3'b110, 4'd1, 4'd5, 3'd6, 3'd7, 3'd0, 16'd4, 16'd3, 16'hFFFC, 1'b0, 16'h0010);
      push(16'd1, 3'd0);
      @(negedge clk);
      check("br_ne_branch", 32'(branch), 32'd1);
      check("br_ne_tgt", 32'(branch_tgt), 32'h000D);
      tick();

      // Flags observed through branch conditions on ADD.
      for (int k = 0; k < 10; k++) begin
         drive(3'b110, 4'd0, ft_cond[k], 3'd6, 3'd7, 3'd0, ft_r1[k], ft_r2[k],
               16'h0010, 1'b0, 16'h0020);
         push(ft_res[k], 3'd0);
         @(negedge clk);
         check($sformatf("flag_br_%0d", k), 32'(branch), 32'(ft_br[k]));
         check($sformatf("flag_tgt_%0d", k), 32'(branch_tgt),
               ft_br[k] ? 32'h0031 : 32'h0021);
         tick();
      end

      // Flush kills a taken branch and its write-back.
      drive(3'b110, 4'd0, 4'd6, 3'd6, 3'd7, 3'd0, 16'd1, 16'd1, 16'h0000, 1'b0, 16'h0020);
      flush = 1'b1;
      @(negedge clk);
      check("flush_branch", 32'(branch), 32'd0);
      tick();

      // Jump-register takes the ALU result.
      drive(3'b111, 4'd7, 4'd0, 3'd6, 3'd7, 3'd0, 16'd0, 16'd0, 16'h1234, 1'b1, 16'h0040);
      push(16'h1234, 3'd0);
      @(negedge clk);
      check("jr_branch", 32'(branch), 32'd1);
      check("jr_tgt", 32'(branch_tgt), 32'h1234);
      tick();
      idle();
      tick();

      // Reset in the middle of a multiply.
      drive(3'b000, 4'd8, 4'd0, 3'd1, 3'd2, 3'd3, 16'd300, 16'd7, 16'd0, 1'b0, 16'h0000);
      tick();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("rstmid_result", 32'(result), 32'd0);
      check("rstmid_store", 32'(store_data), 32'd0);
      check("rstmid_tgt", 32'(tgt_out), 32'd0);
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_stall", 32'(stall), 32'd0);
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid === 1'b1) nv++;
      end
      check("rstmid_no_pulse", 32'(nv), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
